wishbone_sram_slave: RTL

WISHBONE_SRAM_SLAVE -- requirements
Module: wishbone_sram_slave

---
 rtl/wishbone_sram_slave.sv | 117 +++++++++++
 1 files changed

// File: rtl/wishbone_sram_slave.sv
// Wishbone classic slave in front of a 32-bit, byte-lane-writable SRAM.
// A request is captured, held for WAIT_STATES cycles, then acknowledged for one cycle.
module wishbone_sram_slave #(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wishbone_addr_i,
  input  logic [31:0] wishbone_data_i,
  input  logic        wishbone_we_i,
  input  logic [3:0]  wishbone_sel_i,
  input  logic        wishbone_stb_i,
  input  logic        wishbone_cyc_i,
  output logic [31:0] wishbone_data_o,
  output logic        wishbone_ack_o
);

  localparam int         DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [3:0]            r_wait_cnt;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [31:0]           r_data;
  logic                  r_we;
  logic [3:0]            r_sel;

  logic                  w_req;
  logic                  w_capture;
  logic                  w_enter_ack;
  logic                  w_wr_en;
  logic                  w_rd_en;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [31:0]           w_data;
  logic                  w_we;
  logic [3:0]            w_sel;
  logic                  w_unused;

  assign w_req     = wishbone_cyc_i && wishbone_stb_i;
  assign w_capture = (r_state == IDLE) && w_req;

  always_comb begin
    w_next_state = r_state;
    w_enter_ack  = 1'b0;
    case (r_state)
      IDLE: if (w_req) w_next_state = (WAIT_STATES == 0) ? ACK : WAIT;
      WAIT: begin
        if (!w_req) w_next_state = IDLE;
        else if (r_wait_cnt == 4'd0) w_next_state = ACK;
      end
      ACK:     w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
    // Reset on the same edge must suppress the memory access of that edge.
    w_enter_ack = !rst && (w_next_state == ACK);
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (rst)                                     r_wait_cnt <= 4'd0;
    else if (w_capture)                          r_wait_cnt <= WAIT_LOAD;
    else if (r_state == WAIT && r_wait_cnt != 0) r_wait_cnt <= r_wait_cnt - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_idx  <= wishbone_addr_i[ADDR_WIDTH+1:2];
      r_data <= wishbone_data_i;
      r_we   <= wishbone_we_i;
      r_sel  <= wishbone_sel_i;
    end
  end

  // With zero wait states ACK is entered on the capture edge, so the bus feeds the RAM directly.
  assign w_idx   = (r_state == IDLE) ? wishbone_addr_i[ADDR_WIDTH+1:2] : r_idx;
  assign w_data  = (r_state == IDLE) ? wishbone_data_i : r_data;
  assign w_we    = (r_state == IDLE) ? wishbone_we_i   : r_we;
  assign w_sel   = (r_state == IDLE) ? wishbone_sel_i  : r_sel;
  assign w_wr_en = w_enter_ack && w_we;
  assign w_rd_en = w_enter_ack && !w_we;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] r_mem [DEPTH];
      logic [7:0] r_rd_byte;

      always_ff @(posedge clk) begin
        if (w_wr_en && w_sel[gi]) r_mem[w_idx] <= w_data[8*gi +: 8];
      end

      // Read register is live only in the ACK cycle and zero otherwise.
      always_ff @(posedge clk) begin
        if (rst)          r_rd_byte <= 8'd0;
        else if (w_rd_en) r_rd_byte <= r_mem[w_idx];
        else              r_rd_byte <= 8'd0;
      end

      assign wishbone_data_o[8*gi +: 8] = r_rd_byte;
    end
  endgenerate

  assign wishbone_ack_o = (r_state == ACK);
  assign w_unused       = ^{wishbone_addr_i[31:ADDR_WIDTH+2], wishbone_addr_i[1:0]};

endmodule
